// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - FSM state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - one-bit full subtractor built from two half subtractors
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic hs1_d;
   logic hs1_b;
   logic hs2_b;

   // First half subtractor computes x - y, second subtracts the incoming borrow.
   assign hs1_d = x ^ y;
   assign hs1_b = ~x & y;
   assign d     = hs1_d ^ bin;
   assign hs2_b = ~hs1_d & bin;
   assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first serial a-b, one bit per clock
// SERIAL_SUB_SAT_EN: clamp diff to zero when the subtraction borrows.
module bit_serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             bit_d;
   logic             bit_bout;
   logic [WIDTH-1:0] res_shift;

   full_subtractor_cell u_cell (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (bit_d),
      .bout (bit_bout)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;

      // Result fills from the MSB so after WIDTH steps bit 0 holds the first difference bit.
      res_shift            = res_q >> 1;
      res_shift[WIDTH-1]   = bit_d;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               res_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_d    = res_shift;
            borrow_d = bit_bout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
               diff_d = bit_bout ? '0 : res_shift;
`else
               diff_d = res_shift;
`endif
               bout_d  = bit_bout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule
